// File: rtl/reservation_station.sv
// reservation_station
//   Tomasulo reservation station in front of a single functional unit.
//   Renamed instructions are held until both operands are valid (snooping
//   the CDB for pending producer tags), dispatched one at a time to the FU,
//   and the returned result is held on res_* until the CDB arbiter acks it.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   issue_*               : instruction from issue stage; issue_ready/issue_tag
//                           report the lowest free entry
//   cdb_valid/tag/data    : common data bus broadcast being snooped
//   fu_start, fu_*        : dispatch pulse and operands to the FU
//   fu_done/tag_in/dout   : result returned by the FU
//   res_valid/tag/data    : pending CDB request; res_ack is the grant
module reservation_station #(
  parameter int ENTRIES  = 3,
  parameter int TAG_BASE = 1,
  parameter int DATA_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  output logic [2:0]        issue_tag,
  input  logic [DATA_W-1:0] issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [2:0]        issue_qj,
  input  logic [2:0]        issue_qk,
  input  logic              cdb_valid,
  input  logic [2:0]        cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              fu_start,
  output logic [DATA_W-1:0] fu_instruction,
  output logic [2:0]        fu_tag,
  output logic [DATA_W-1:0] fu_reg1,
  output logic [DATA_W-1:0] fu_reg2,
  input  logic              fu_done,
  input  logic [2:0]        fu_tag_in,
  input  logic [DATA_W-1:0] fu_dout,
  output logic              res_valid,
  output logic [2:0]        res_tag,
  output logic [DATA_W-1:0] res_data,
  input  logic              res_ack
);

  typedef enum logic [2:0] {S_FREE, S_WAIT, S_READY, S_EXEC, S_DONE} state_t;

  state_t            state [ENTRIES];
  logic [DATA_W-1:0] op_q  [ENTRIES];
  logic [DATA_W-1:0] vj_q  [ENTRIES];
  logic [DATA_W-1:0] vk_q  [ENTRIES];
  logic [2:0]        qj_q  [ENTRIES];
  logic [2:0]        qk_q  [ENTRIES];

  logic fu_busy;
  logic free_found, ready_found, done_any;
  int   free_idx, ready_idx;
  logic issue_fire, dispatch, complete, release_res;

  function automatic logic [2:0] tag_of(input int idx);
    return 3'(TAG_BASE + idx);
  endfunction

  // A pending tag that matches the current broadcast is satisfied.
  function automatic logic cdb_hit(input logic [2:0] q, input logic cv,
                                   input logic [2:0] ct);
    return cv && (q != 3'd0) && (q == ct);
  endfunction

  function automatic logic [2:0] resolve_q(input logic [2:0] q, input logic cv,
                                           input logic [2:0] ct);
    return cdb_hit(q, cv, ct) ? 3'd0 : q;
  endfunction

  always_comb begin
    free_found  = 1'b0;
    ready_found = 1'b0;
    done_any    = 1'b0;
    free_idx    = 0;
    ready_idx   = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (state[i] == S_FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = i;
      end
      if (state[i] == S_READY && !ready_found) begin
        ready_found = 1'b1;
        ready_idx   = i;
      end
      if (state[i] == S_DONE) done_any = 1'b1;
    end
  end

  assign issue_ready = free_found;
  assign issue_tag   = tag_of(free_idx);
  assign issue_fire  = issue_valid && free_found;
  // Holding dispatch while a result is pending keeps the FU idle until ack.
  assign dispatch    = !fu_busy && !done_any && ready_found;
  // The FU cannot legally answer in the same cycle it is started.
  assign complete    = fu_done && fu_busy && !fu_start && (fu_tag_in == fu_tag);
  assign release_res = res_valid && res_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) state[i] <= S_FREE;
      fu_busy        <= 1'b0;
      fu_start       <= 1'b0;
      fu_instruction <= '0;
      fu_tag         <= '0;
      fu_reg1        <= '0;
      fu_reg2        <= '0;
      res_valid      <= 1'b0;
      res_tag        <= '0;
      res_data       <= '0;
    end else begin
      fu_start <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        case (state[i])
          S_FREE: if (issue_fire && free_idx == i) begin
            op_q[i] <= issue_op;
            vj_q[i] <= cdb_hit(issue_qj, cdb_valid, cdb_tag) ? cdb_data : issue_vj;
            vk_q[i] <= cdb_hit(issue_qk, cdb_valid, cdb_tag) ? cdb_data : issue_vk;
            qj_q[i] <= resolve_q(issue_qj, cdb_valid, cdb_tag);
            qk_q[i] <= resolve_q(issue_qk, cdb_valid, cdb_tag);
            state[i] <= (resolve_q(issue_qj, cdb_valid, cdb_tag) != 3'd0 ||
                         resolve_q(issue_qk, cdb_valid, cdb_tag) != 3'd0)
                        ? S_WAIT : S_READY;
          end
          S_WAIT: begin
            if (cdb_hit(qj_q[i], cdb_valid, cdb_tag)) vj_q[i] <= cdb_data;
            if (cdb_hit(qk_q[i], cdb_valid, cdb_tag)) vk_q[i] <= cdb_data;
            qj_q[i] <= resolve_q(qj_q[i], cdb_valid, cdb_tag);
            qk_q[i] <= resolve_q(qk_q[i], cdb_valid, cdb_tag);
            if (resolve_q(qj_q[i], cdb_valid, cdb_tag) == 3'd0 &&
                resolve_q(qk_q[i], cdb_valid, cdb_tag) == 3'd0)
              state[i] <= S_READY;
          end
          S_READY: if (dispatch && ready_idx == i) begin
            state[i]       <= S_EXEC;
            fu_instruction <= op_q[i];
            fu_tag         <= tag_of(i);
            fu_reg1        <= vj_q[i];
            fu_reg2        <= vk_q[i];
          end
          S_EXEC: if (complete && fu_tag == tag_of(i)) state[i] <= S_DONE;
          S_DONE: if (release_res && res_tag == tag_of(i)) state[i] <= S_FREE;
          default: state[i] <= S_FREE;
        endcase
      end
      if (dispatch) begin
        fu_busy  <= 1'b1;
        fu_start <= 1'b1;
      end
      // Completion and ack never coincide: no dispatch happens while DONE.
      if (complete) begin
        fu_busy   <= 1'b0;
        res_valid <= 1'b1;
        res_tag   <= fu_tag_in;
        res_data  <= fu_dout;
      end else if (release_res) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Tomasulo reservation station feeding one functional unit: accepts renamed instructions from the issue stage, holds them until both operands are valid, and snoops the common data bus (CDB) for pending operands. It dispatches ready entries to the functional unit and captures the result. It then broadcasts the result on the CDB under the entry's tag until the CDB arbiter grants it.

## Interface
- ENTRIES, 3: number of station entries (1..7).
- TAG_BASE, 1: tag of entry 0; entry i owns tag TAG_BASE+i. Tag 0 is reserved for "operand valid". TAG_BASE+ENTRIES-1 must be ≤ 7.

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  issue stage presents an instruction
- issue_ready  out  1  at least one entry FREE (registered state only)
- issue_tag  out  3  tag of lowest-index FREE entry; valid when issue_ready
- issue_op  in  16  instruction word; opcode in [3:0], passed through untouched
- issue_vj, issue_vk  in  16  operand values
- issue_qj, issue_qk  in  3  producer tags; 0 = value in vj/vk is valid
- cdb_valid  in  1  CDB broadcast this cycle (includes this station's own)
- cdb_tag  in  3  broadcast tag
- cdb_data  in  16  broadcast value
- fu_start  out  1  one-cycle dispatch pulse to the FU
- fu_instruction  out  16  dispatched instruction word
- fu_tag  out  3  dispatched entry tag
- fu_reg1, fu_reg2  out  16  dispatched operands
- fu_done  in  1  FU result valid
- fu_tag_in  in  3  tag returned by the FU with the result
- fu_dout  in  16  FU result
- res_valid  out  1  result pending on CDB request
- res_tag  out  3  tag of the pending result
- res_data  out  16  pending result value
- res_ack  in  1  CDB grant; result taken this cycle

## Operation
- Entry states: FREE, WAIT (a qj/qk is nonzero), READY, EXEC, DONE.
- Issue: on issue_valid && issue_ready, the lowest-index FREE entry loads op/v/q. It goes to WAIT if any q is nonzero, else READY. issue_valid while !issue_ready is ignored and does not cause an error.
- Issue/CDB bypass: if cdb_valid and cdb_tag equals a nonzero issue_qj/qk in the same cycle, the entry stores cdb_data and clears that q.
- Snoop: each WAIT entry with q == cdb_tag (nonzero) captures cdb_data and clears q. When both q are 0, the entry goes to READY at the next edge.
- Dispatch: fires when the FU is idle, no entry is in DONE, and some entry is READY (registered state). The lowest-index READY entry is selected and goes to EXEC. fu_start is pulsed and the fu_* outputs are loaded. An entry that becomes READY this cycle is eligible next cycle.
- Completion: fu_done && fu_busy && fu_tag_in == in-flight tag. On that edge: fu_busy clears, the entry goes to DONE, and res_data/res_tag load with res_valid=1. Only the first matching fu_done is accepted. fu_done while idle, or with a mismatched tag, is ignored.
- Broadcast: res_* are held stable while res_valid. On res_ack && res_valid, the entry goes to FREE and res_valid=0 at that edge. The freed entry is allocatable from the next cycle.
- Result arithmetic is entirely in the FU. This block moves 16-bit values only.

## Timing
- Reset values: all entries FREE, fu_busy=0, fu_start=0, res_valid=0. fu_instruction, fu_tag, fu_reg1, fu_reg2, res_tag and res_data are 0. issue_ready=1 and issue_tag=TAG_BASE one cycle after reset.
- Reset mid-operation discards all entries and in-flight work. fu_done after reset is ignored because fu_busy=0.
- Issue at edge N: READY entry dispatches at edge N+1 (fu_start high in cycle N+1), at the earliest.
- fu_done is accepted no earlier than the cycle after fu_start.
- res_valid rises at the edge where fu_done is sampled and stays high until the res_ack edge.
- Minimum issue-to-free latency: issue, dispatch, FU latency, and ack of at least 1 cycle.
- fu_* outputs hold between fu_start and accepted fu_done. fu_start is never high for 2 consecutive cycles.

## Test plan
- Reset, then issue op=0x0000, vj=5, vk=7, q=0. Expect fu_start one cycle later with reg1=5, reg2=7, tag=1. FU returns done with dout=12 → res_valid, tag=1, data=12. After res_ack, entry is FREE.
- Issue with qj=4. Two cycles later drive cdb tag 4 with data 0x00AA. Expect dispatch the cycle after capture, with reg1=0x00AA.
- Issue with qk=5 while cdb_valid, tag=5, data=9 occurs in the same cycle. Expect reg2=9 at dispatch and no WAIT stall.
- Fill all 3 entries. Expect issue_ready=0 and further issue_valid ignored. Dispatch order must be tags 1, 2, 3. Hold res_ack low after the first result: no second fu_start until the ack.
- Mismatched fu_tag_in=6 and spurious fu_done while idle are both ignored. Assert reset while an entry is in EXEC. Then: all outputs at reset values, and a later fu_done produces no res_valid.
